// File: rtl/bmp_pixel_streamer_if.sv
// bmp_pixel_streamer_if: byte-wide synchronous read bus.
// Read data is valid one cycle after the read strobe.
interface bmp_pixel_streamer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data
  );
endinterface

// File: rtl/bmp_pixel_streamer.sv
// bmp_pixel_streamer: replays a 24-bit bottom-up BMP pixel array.
// Option BMP_TEST_PATTERN_EN adds a memory-free test pattern source.
module bmp_pixel_streamer #(
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int BASE_ADDR = 54,
  parameter int ADDR_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       hold_i,
`ifdef BMP_TEST_PATTERN_EN
  input  logic       test_pattern_i,
`endif
  bmp_pixel_streamer_if.master mem,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       cam_done_o,
  output logic       frame_done_o,
  output logic       busy_o
);

  localparam int S   = ((3 * IMG_W + 3) / 4) * 4;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AFW = (ADDR_W > 32) ? ADDR_W : 32;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_B  = 3'd1;
  localparam logic [2:0] RD_G  = 3'd2;
  localparam logic [2:0] RD_R  = 3'd3;
  localparam logic [2:0] LAT_R = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    blue_cap_q, green_cap_q;
  logic [7:0]    red_q, green_q, blue_q;
  logic          cam_q, fdone_q;
  logic          last_px;
  logic          rd_en;
  logic [1:0]    byte_sel;
  logic [AFW-1:0] addr_full;

`ifdef BMP_TEST_PATTERN_EN
  logic tp_q, tp_d;
`endif

  assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Byte offset within the BGR triplet for the read in flight
  always_comb begin
    byte_sel = 2'd0;
    unique case (1'b1)
      (state_q == RD_G): byte_sel = 2'd1;
      (state_q == RD_R): byte_sel = 2'd2;
      default:           byte_sel = 2'd0;
    endcase
  end

  // Rows are stored bottom-up, so output row r maps to line H-1-r
  assign addr_full = AFW'(BASE_ADDR)
                   + (AFW'(ROW_LAST) - AFW'(row_q)) * AFW'(S)
                   + AFW'(col_q) * AFW'(3)
                   + AFW'(byte_sel);

  // Read strobe: suppressed under backpressure or pattern mode
  always_comb begin
    rd_en = 1'b0;
    unique case (1'b1)
      (state_q == RD_B): rd_en = !hold_i;
      (state_q == RD_G): rd_en = 1'b1;
      (state_q == RD_R): rd_en = 1'b1;
      default:           rd_en = 1'b0;
    endcase
`ifdef BMP_TEST_PATTERN_EN
    if (tp_q) rd_en = 1'b0;
`endif
  end

  assign mem.mem_rd   = rd_en;
  assign mem.mem_addr = rd_en ? addr_full[ADDR_W-1:0]
                              : '0;

  // Next state and pixel counters
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
`ifdef BMP_TEST_PATTERN_EN
    tp_d    = tp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i && !fdone_q) begin
          state_d = RD_B;
`ifdef BMP_TEST_PATTERN_EN
          tp_d    = test_pattern_i;
`endif
        end
      end
      RD_B: if (!hold_i) state_d = RD_G;
      RD_G: state_d = RD_R;
      RD_R: state_d = LAT_R;
      LAT_R: begin
        if (last_px) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else if (col_q == COL_LAST) begin
          state_d = RD_B;
          col_d   = '0;
          row_d   = row_q + 1'b1;
        end else begin
          state_d = RD_B;
          col_d   = col_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

`ifdef BMP_TEST_PATTERN_EN
  // Pattern mode latched at frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tp_q <= 1'b0;
    else      tp_q <= tp_d;
  end
`endif

  // Byte capture and pixel output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blue_cap_q  <= '0;
      green_cap_q <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      cam_q       <= 1'b0;
      fdone_q     <= 1'b0;
    end else begin
      cam_q   <= 1'b0;
      fdone_q <= 1'b0;
      if (state_q == RD_G) blue_cap_q  <= mem.mem_data;
      if (state_q == RD_R) green_cap_q <= mem.mem_data;
      if (state_q == LAT_R) begin
        cam_q   <= 1'b1;
        fdone_q <= last_px;
        red_q   <= mem.mem_data;
        green_q <= green_cap_q;
        blue_q  <= blue_cap_q;
`ifdef BMP_TEST_PATTERN_EN
        if (tp_q) begin
          red_q   <= 8'(col_q);
          green_q <= 8'(row_q);
          blue_q  <= 8'(col_q) + 8'(row_q);
        end
`endif
      end
    end
  end

  assign red_o        = red_q;
  assign green_o      = green_q;
  assign blue_o       = blue_q;
  assign cam_done_o   = cam_q;
  assign frame_done_o = fdone_q;
  assign busy_o       = (state_q != IDLE) || fdone_q;

endmodule

// File: tb/tb_bmp_pixel_streamer.sv
// tb_bmp_pixel_streamer: directed + random-memory checks
// of bmp_pixel_streamer against a BMP address/pixel model.
module tb_bmp_pixel_streamer;

  localparam int W    = 5;
  localparam int H    = 2;
  localparam int BASE = 54;
  localparam int S    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start_s = 1'b0, hold_s = 1'b0;
  logic start_b = 1'b0, hold_b = 1'b0;
`ifdef BMP_TEST_PATTERN_EN
  logic tp_s = 1'b0, tp_b = 1'b0;
`endif

  logic [7:0] red_s, green_s, blue_s;
  logic       cam_s, fd_s, busy_s;
  logic [7:0] red_b, green_b, blue_b;
  logic       cam_b, fd_b, busy_b;

  bmp_pixel_streamer_if #(.ADDR_W(16)) ms ();
  bmp_pixel_streamer_if #(.ADDR_W(16)) mb ();

  bmp_pixel_streamer #(
    .IMG_W(W), .IMG_H(H),
    .BASE_ADDR(BASE), .ADDR_W(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .start_i(start_s), .hold_i(hold_s),
`ifdef BMP_TEST_PATTERN_EN
    .test_pattern_i(tp_s),
`endif
    .mem(ms),
    .red_o(red_s), .green_o(green_s),
    .blue_o(blue_s), .cam_done_o(cam_s),
    .frame_done_o(fd_s), .busy_o(busy_s)
  );

  bmp_pixel_streamer #(
    .IMG_W(128), .IMG_H(128),
    .BASE_ADDR(54), .ADDR_W(16)
  ) u_big (
    .clk(clk), .rst(rst),
    .start_i(start_b), .hold_i(hold_b),
`ifdef BMP_TEST_PATTERN_EN
    .test_pattern_i(tp_b),
`endif
    .mem(mb),
    .red_o(red_b), .green_o(green_b),
    .blue_o(blue_b), .cam_done_o(cam_b),
    .frame_done_o(fd_b), .busy_o(busy_b)
  );

  // memories: small one from a table, big one returns addr[7:0]
  logic [7:0] mem_s [256];
  always @(posedge clk)
    if (ms.mem_rd) ms.mem_data <= mem_s[ms.mem_addr[7:0]];
  always @(posedge clk)
    if (mb.mem_rd) mb.mem_data <= mb.mem_addr[7:0];

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int         cyc;
    logic [7:0] r, g, b;
    logic       fd;
  } ev_t;

  ev_t evq[$];
  int  fd_cnt = 0, rd_cnt = 0, pad_rd = 0;
  int  busy_last = 0;

  always @(negedge clk) begin
    if (cam_s)
      evq.push_back('{ecount, red_s, green_s, blue_s, fd_s});
    if (fd_s) fd_cnt++;
    if (ms.mem_rd) begin
      rd_cnt++;
      if (ms.mem_addr == 16'd69 || ms.mem_addr == 16'd85)
        pad_rd++;
    end
    if (busy_s) busy_last = ecount;
  end

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic goto(input int t);
    while (ecount < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int paddr(int r, int c);
    return BASE + (H - 1 - r) * S + 3 * c;
  endfunction

  int tb, t0, t1, ev0, fd0, rd0, pad0, n, k, pr;
  int rr, cc, a;
  logic [7:0] eb;

  initial begin
    for (int i = 0; i < 256; i++) mem_s[i] = 8'(i);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_red", red_s, 0);
    chk("rst_cam", cam_s, 0);
    chk("rst_fd", fd_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_rd", ms.mem_rd, 0);
    chk("rst_addr", ms.mem_addr, 0);
    rst = 1'b1;

    // big frame: first address, then async reset mid-frame
    @(posedge clk); #1;
    start_b = 1'b1;
    tb = ecount;
    goto(tb + 1);
    start_b = 1'b0;
    chk("big_rd0", mb.mem_rd, 1);
    chk("big_addr0", mb.mem_addr, 48822);
    goto(tb + 1204);
    chk("big_busy", busy_b, 1);
    eb = 8'(54 + (127 - 2) * 384 + 3 * 43 + 2);
    chk("big_px299_r", red_b, eb);
    #2 rst = 1'b0;
    #1;
    chk("arst_red", red_b, 0);
    chk("arst_grn", green_b, 0);
    chk("arst_blu", blue_b, 0);
    chk("arst_cam", cam_b, 0);
    chk("arst_fd", fd_b, 0);
    chk("arst_busy", busy_b, 0);
    chk("arst_rd", mb.mem_rd, 0);
    chk("arst_addr", mb.mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b1;
    tb = ecount;
    goto(tb + 1);
    start_b = 1'b0;
    chk("big_rd1", mb.mem_rd, 1);
    chk("big_addr1", mb.mem_addr, 48822);

    // small frame 1: memory byte = address
    @(posedge clk); #1;
    start_s = 1'b1;
    t0 = ecount;
    ev0 = evq.size(); fd0 = fd_cnt;
    rd0 = rd_cnt; pad0 = pad_rd;
    goto(t0 + 1);
    start_s = 1'b0;
    chk("f1_busy1", busy_s, 1);
    goto(t0 + 20);
    start_s = 1'b1;
    goto(t0 + 21);
    start_s = 1'b0;
    goto(t0 + 41);
    chk("f1_busy41", busy_s, 1);
    chk("f1_fd41", fd_s, 1);
    start_s = 1'b1;
    goto(t0 + 42);
    chk("f1_busy42", busy_s, 0);
    chk("f1_fd42", fd_s, 0);
    goto(t0 + 43);
    start_s = 1'b0;
    chk("f2_rd_start", ms.mem_rd, 1);
    chk("f2_addr_start", ms.mem_addr, 70);
    n = evq.size() - ev0;
    chk("f1_npix", n, 10);
    chk("f1_nfd", fd_cnt - fd0, 1);
    chk("f1_nrd", rd_cnt - rd0, 30);
    chk("f1_pad", pad_rd - pad0, 0);
    if (n >= 10) begin
      chk("f1_p0_b", evq[ev0].b, 70);
      chk("f1_p0_g", evq[ev0].g, 71);
      chk("f1_p0_r", evq[ev0].r, 72);
      chk("f1_p5_b", evq[ev0 + 5].b, 54);
      chk("f1_p5_r", evq[ev0 + 5].r, 56);
      chk("f1_p9_b", evq[ev0 + 9].b, 66);
      chk("f1_p9_g", evq[ev0 + 9].g, 67);
      chk("f1_p9_r", evq[ev0 + 9].r, 68);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < n) begin
        chk("f1_cyc", evq[ev0 + i].cyc - t0, 5 + 4 * i);
        chk("f1_fdflag", evq[ev0 + i].fd, i == 9);
      end
    end

    // small frame 2: random memory, backpressure
    for (int i = 0; i < 256; i++) mem_s[i] = 8'($urandom);
    t1 = t0 + 42;
    ev0 = evq.size(); fd0 = fd_cnt;
    rd0 = rd_cnt; pad0 = pad_rd;
    for (int c = 13; c <= 18; c++) begin
      goto(t1 + c);
      hold_s = 1'b1;
      #1;
      chk("hold_rd", ms.mem_rd, 0);
    end
    goto(t1 + 19);
    hold_s = 1'b0;
    pr = $urandom_range(25, 30);
    goto(t1 + pr);
    start_s = 1'b1;
    goto(t1 + pr + 1);
    start_s = 1'b0;
    goto(t1 + 50);
    chk("f2_busy50", busy_s, 0);
    chk("f2_busylast", busy_last - t1, 47);
    n = evq.size() - ev0;
    chk("f2_npix", n, 10);
    chk("f2_nfd", fd_cnt - fd0, 1);
    chk("f2_nrd", rd_cnt - rd0, 30);
    chk("f2_pad", pad_rd - pad0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i < n) begin
        rr = i / W;
        cc = i % W;
        a  = paddr(rr, cc);
        k  = (i < 3) ? 5 + 4 * i : 11 + 4 * i;
        chk("f2_cyc", evq[ev0 + i].cyc - t1, k);
        chk("f2_b", evq[ev0 + i].b, mem_s[a]);
        chk("f2_g", evq[ev0 + i].g, mem_s[a + 1]);
        chk("f2_r", evq[ev0 + i].r, mem_s[a + 2]);
        chk("f2_fdflag", evq[ev0 + i].fd, i == 9);
      end
    end

`ifdef BMP_TEST_PATTERN_EN
    // small frame 3: test pattern, no memory traffic
    tp_s = 1'b1;
    start_s = 1'b1;
    t1 = ecount;
    ev0 = evq.size(); rd0 = rd_cnt;
    goto(t1 + 1);
    start_s = 1'b0;
    tp_s = 1'b0;
    goto(t1 + 45);
    n = evq.size() - ev0;
    chk("tp_npix", n, 10);
    chk("tp_nrd", rd_cnt - rd0, 0);
    if (n >= 10) begin
      chk("tp_p8_r", evq[ev0 + 8].r, 3);
      chk("tp_p8_g", evq[ev0 + 8].g, 1);
      chk("tp_p8_b", evq[ev0 + 8].b, 4);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < n) begin
        chk("tp_r", evq[ev0 + i].r, i % W);
        chk("tp_g", evq[ev0 + i].g, i / W);
        chk("tp_b", evq[ev0 + i].b, i % W + i / W);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
